// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter: shares one parallel EEPROM bus between a page writer (port 0)
// and a read-back engine (port 1). It uses round-robin arbitration with burst
// lock, sequences byte reads and writes, and runs Data# polling on its own
// after every burst that contained writes.
module eeprom_arbiter #(
    parameter int unsigned RD_CYC       = 2,
    parameter int unsigned WE_CYC       = 2,
    parameter int unsigned POLL_TIMEOUT = 70000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  req,
    input  logic [1:0]  lock,
    input  logic [1:0]  wr,
    input  logic [16:0] addr0,
    input  logic [16:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        err,
    output logic [16:0] mem_addr,
    inout  wire  [7:0]  data_io,
    output logic        nce,
    output logic        noe,
    output logic        nwe
);

    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CYC_MAX = (RD_CYC > WE_CYC) ? RD_CYC : WE_CYC;
    localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned PT_W    = $clog2(POLL_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYC - 1);
    localparam logic [PT_W-1:0]  PT_LAST = PT_W'(POLL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_POLL_RD,
        S_POLL_GAP
    } state_t;

    state_t              r_state;
    logic [1:0]          r_gnt;
    logic [1:0]          r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic                r_nce;
    logic                r_noe;
    logic                r_nwe;
    logic                r_dirty;
    logic                r_rr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [DATA_W-1:0]   r_last_data;
    logic [CNT_W-1:0]    r_cnt;
    logic [PT_W-1:0]     r_pcnt;

    logic                w_own;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W-1:0]   w_own_wdata;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [PT_W-1:0]     w_pcnt_inc;
    logic                w_poll_match;

    assign w_own        = r_gnt[1];
    assign w_own_addr   = w_own ? addr1 : addr0;
    assign w_own_wdata  = w_own ? wdata1 : wdata0;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_pcnt_inc   = r_pcnt + PT_W'(1);
    assign w_poll_match = (data_io[7] == r_last_data[7]);

    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign err      = r_err;
    assign mem_addr = r_addr;
    assign nce      = r_nce;
    assign noe      = r_noe;
    assign nwe      = r_nwe;
    assign data_io  = r_drive ? r_wdata : {DATA_W{1'bz}};

    // Arbitration, bus-cycle sequencing and Data# polling; every output is registered here.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_drive     <= 1'b0;
            r_nce       <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_dirty     <= 1'b0;
            r_rr        <= 1'b0;
            r_last_addr <= '0;
            r_last_data <= '0;
            r_cnt       <= '0;
            r_pcnt      <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (r_gnt == 2'b00) begin
                        if (req == 2'b11) begin
                            r_gnt <= r_rr ? 2'b10 : 2'b01;
                        end else if (req[0]) begin
                            r_gnt <= 2'b01;
                        end else if (req[1]) begin
                            r_gnt <= 2'b10;
                        end
                    end else if (req[w_own]) begin
                        r_addr  <= w_own_addr;
                        r_wdata <= w_own_wdata;
                        r_cnt   <= '0;
                        r_nce   <= 1'b0;
                        if (wr[w_own]) begin
                            r_state <= S_WR_SETUP;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                            r_noe   <= 1'b0;
                            if (RD_CYC == 1) begin
                                r_ack   <= r_gnt;
                                r_rdata <= data_io;
                            end
                        end
                    end else if (!lock[w_own]) begin
                        r_gnt <= '0;
                        r_rr  <= ~w_own;
                        if (r_dirty) begin
                            r_state <= S_POLL_RD;
                            r_busy  <= 1'b1;
                            r_nce   <= 1'b0;
                            r_noe   <= 1'b0;
                            r_addr  <= r_last_addr;
                            r_cnt   <= '0;
                            r_pcnt  <= '0;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_state <= S_IDLE;
                        r_nce   <= 1'b1;
                        r_noe   <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // ack and read data are registered so they sit in the last strobe cycle
                        if (w_cnt_inc == RD_LAST) begin
                            r_ack   <= r_gnt;
                            r_rdata <= data_io;
                        end
                    end
                end
                S_WR_SETUP: begin
                    r_state <= S_WR_PULSE;
                    r_nwe   <= 1'b0;
                    r_cnt   <= '0;
                end
                S_WR_PULSE: begin
                    if (r_cnt == WE_LAST) begin
                        r_state     <= S_WR_HOLD;
                        r_nwe       <= 1'b1;
                        r_ack       <= r_gnt;
                        r_dirty     <= 1'b1;
                        r_last_addr <= r_addr;
                        r_last_data <= r_wdata;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_WR_HOLD: begin
                    r_state <= S_IDLE;
                    r_nce   <= 1'b1;
                    r_drive <= 1'b0;
                end
                S_POLL_RD: begin
                    r_pcnt <= w_pcnt_inc;
                    if ((r_cnt == RD_LAST) && w_poll_match) begin
                        r_state <= S_IDLE;
                        r_nce   <= 1'b1;
                        r_noe   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_dirty <= 1'b0;
                    end else if (r_pcnt == PT_LAST) begin
                        r_state <= S_IDLE;
                        r_nce   <= 1'b1;
                        r_noe   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_dirty <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (r_cnt == RD_LAST) begin
                        r_state <= S_POLL_GAP;
                        r_nce   <= 1'b1;
                        r_noe   <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_POLL_GAP: begin
                    r_pcnt <= w_pcnt_inc;
                    if (r_pcnt == PT_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_dirty <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_POLL_RD;
                        r_nce   <= 1'b0;
                        r_noe   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed testbench for eeprom_arbiter with a byte-wide EEPROM model on data_io.
module tb_eeprom_arbiter;

    localparam int unsigned RD_CYC  = 2;
    localparam int unsigned WE_CYC  = 2;
    localparam int unsigned POLL_TO = 1000;

    logic        clk;
    logic        nrst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  wr;
    logic [16:0] addr0;
    logic [16:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic        err;
    logic [16:0] mem_addr;
    wire  [7:0]  data_io;
    logic        nce;
    logic        noe;
    logic        nwe;

    int n_tests;
    int n_fail;

    // EEPROM model: preloaded bytes until written; optional bit7 inversion emulates a busy part
    logic [7:0] mem [0:131071];
    bit         written [0:131071];
    logic       poll_inv;
    logic [7:0] model_byte;

    function automatic logic [7:0] preload(input logic [16:0] a);
        case (a)
            17'h00010: return 8'hA5;
            17'h00020: return 8'h3C;
            17'h00021: return 8'hC3;
            default:   return 8'hFF;
        endcase
    endfunction

    assign model_byte = written[mem_addr] ? mem[mem_addr] : preload(mem_addr);
    assign data_io    = (!nce && !noe) ? (model_byte ^ (poll_inv ? 8'h80 : 8'h00)) : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data_io[g]);
    end

    always @(posedge nwe) begin
        if (!nce) begin
            mem[mem_addr]     <= data_io;
            written[mem_addr] <= 1'b1;
        end
    end

    eeprom_arbiter #(
        .RD_CYC       (RD_CYC),
        .WE_CYC       (WE_CYC),
        .POLL_TIMEOUT (POLL_TO)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .lock     (lock),
        .wr       (wr),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .err      (err),
        .mem_addr (mem_addr),
        .data_io  (data_io),
        .nce      (nce),
        .noe      (noe),
        .nwe      (nwe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op on port p and wait (bounded) for its ack; flags protocol violations seen meanwhile
    task automatic run_op(input int p, input bit w, input logic [16:0] a, input logic [7:0] d,
                          input bit keep_lock, output logic [7:0] rd, output int lat, output bit got);
        bit viol;
        viol = 1'b0;
        got  = 1'b0;
        lat  = 0;
        rd   = 8'h00;
        wr[p] = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        req[p] = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            lat++;
            if (((ack & ~gnt) != 2'b00) || (!noe && !nwe)) viol = 1'b1;
            if (ack[p]) begin
                got = 1'b1;
                rd  = rdata;
            end
        end
        req[p] = 1'b0;
        if (!keep_lock) lock[p] = 1'b0;
        n_tests++;
        if (viol) begin
            n_fail++;
            $display("FAIL op_protocol: port %0d addr %h saw ack without gnt or noe/nwe both low", p, a);
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL op_timeout: port %0d addr %h got ack=0 required ack=1 within 200 cycles", p, a);
        end
    endtask

    // Locked SDP preamble plus a 128-byte page from port 0; returns the number of acks
    task automatic do_burst(output int n_ack);
        logic [7:0] rd;
        int         lat;
        bit         got;
        logic [16:0] sdp_a [3];
        logic [7:0]  sdp_d [3];
        sdp_a[0] = 17'h05555; sdp_d[0] = 8'hAA;
        sdp_a[1] = 17'h02AAA; sdp_d[1] = 8'h55;
        sdp_a[2] = 17'h05555; sdp_d[2] = 8'hA0;
        n_ack   = 0;
        lock[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(0, 1'b1, sdp_a[i], sdp_d[i], 1'b1, rd, lat, got);
            if (got) n_ack++;
        end
        for (int i = 0; i < 128; i++) begin
            run_op(0, 1'b1, 17'(i), 8'(i), (i != 127), rd, lat, got);
            if (got) n_ack++;
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        req = '0; lock = '0; wr = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        poll_inv = 1'b0;
        tick(); tick();
        n_tests++;
        if ({gnt, ack, busy, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/ack/busy/err=%b required 000000", {gnt, ack, busy, err});
        end
        n_tests++;
        if ({nce, noe, nwe} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_strobes: nce/noe/nwe=%b required 111", {nce, noe, nwe});
        end
        n_tests++;
        if (rdata !== 8'h00 || mem_addr !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_regs: rdata=%h mem_addr=%h required 00 00000", rdata, mem_addr);
        end
        n_tests++;
        if (data_io !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_bus: data_io=%h required FF (released)", data_io);
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_read_p1;
        wr[1] = 1'b0; addr1 = 17'h00010; req[1] = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_grant: gnt=%b required 10", gnt);
        end
        tick();
        n_tests++;
        if ({nce, noe, nwe} !== 3'b001 || ack !== 2'b00 || mem_addr !== 17'h00010 || data_io !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_strobe: nce/noe/nwe=%b ack=%b addr=%h data=%h required 001 00 00010 A5",
                     {nce, noe, nwe}, ack, mem_addr, data_io);
        end
        tick();
        n_tests++;
        if (ack !== 2'b10 || rdata !== 8'hA5 || nwe !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ack: ack=%b rdata=%h nwe=%b required 10 A5 1", ack, rdata, nwe);
        end
        req[1] = 1'b0;
        tick();
        n_tests++;
        if (ack !== 2'b00 || {nce, noe} !== 2'b11 || data_io !== 8'hFF || rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_end: ack=%b nce/noe=%b data=%h rdata=%h required 00 11 FF A5",
                     ack, {nce, noe}, data_io, rdata);
        end
        tick(); tick();
    endtask

    task automatic test_rr;
        logic [7:0] rd;
        int         lat;
        bit         got;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        wr = 2'b00; addr0 = 17'h00020; addr1 = 17'h00021; req = 2'b11;
        tick();
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_first: gnt=%b required 01", gnt);
        end
        run_op(0, 1'b0, 17'h00020, 8'h00, 1'b0, rd, lat, got);
        n_tests++;
        if (rd !== 8'h3C) begin
            n_fail++;
            $display("FAIL rr_p0_data: rdata=%h required 3C", rd);
        end
        run_op(1, 1'b0, 17'h00021, 8'h00, 1'b0, rd, lat, got);
        n_tests++;
        if (rd !== 8'hC3) begin
            n_fail++;
            $display("FAIL rr_p1_data: rdata=%h required C3", rd);
        end
        tick(); tick();
        req = 2'b11;
        tick();
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_ptr_back: gnt=%b required 01", gnt);
        end
        req = 2'b00;
        tick(); tick(); tick();
        n_tests++;
        if (gnt !== 2'b00 || ack !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_release: gnt=%b ack=%b required 00 00", gnt, ack);
        end
    endtask

    task automatic test_burst_poll;
        int         n_ack;
        bit         bad;
        bit         seen;
        logic [7:0] rd;
        int         lat;
        bit         got;
        poll_inv = 1'b1;
        do_burst(n_ack);
        n_tests++;
        if (n_ack != 131) begin
            n_fail++;
            $display("FAIL burst_acks: acks=%0d required 131", n_ack);
        end
        n_tests++;
        if (mem[17'h05555] !== 8'hA0 || mem[17'h02AAA] !== 8'h55 || mem[17'h0007F] !== 8'h7F
            || mem[17'h00040] !== 8'h40) begin
            n_fail++;
            $display("FAIL burst_data: 5555=%h 2AAA=%h 007F=%h 0040=%h required A0 55 7F 40",
                     mem[17'h05555], mem[17'h02AAA], mem[17'h0007F], mem[17'h00040]);
        end
        tick(); tick();
        n_tests++;
        if (busy !== 1'b1 || mem_addr !== 17'h0007F || gnt !== 2'b00 || {nce, noe} !== 2'b00) begin
            n_fail++;
            $display("FAIL poll_start: busy=%b addr=%h gnt=%b nce/noe=%b required 1 0007F 00 00",
                     busy, mem_addr, gnt, {nce, noe});
        end
        wr[1] = 1'b0; addr1 = 17'h00010; req[1] = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (busy !== 1'b1 || gnt !== 2'b00 || ack !== 2'b00) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL poll_hold: busy dropped or grant/ack seen while device busy");
        end
        poll_inv = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (busy === 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (!seen || gnt !== 2'b00 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL poll_done: busy_fell=%b gnt=%b err=%b required 1 00 0", seen, gnt, err);
        end
        tick();
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL poll_then_grant: gnt=%b required 10", gnt);
        end
        run_op(1, 1'b0, 17'h00010, 8'h00, 1'b0, rd, lat, got);
        n_tests++;
        if (rd !== 8'h10) begin
            n_fail++;
            $display("FAIL poll_p1_read: rdata=%h required 10", rd);
        end
        tick(); tick();
    endtask

    task automatic test_timeout;
        int         n_ack;
        bit         bad;
        logic [7:0] rd;
        int         lat;
        bit         got;
        poll_inv = 1'b1;
        do_burst(n_ack);
        n_tests++;
        if (n_ack != 131) begin
            n_fail++;
            $display("FAIL to_burst_acks: acks=%0d required 131", n_ack);
        end
        tick(); tick();
        bad = (busy !== 1'b1);
        for (int i = 1; i < 1000; i++) begin
            tick();
            if (busy !== 1'b1 || err !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL to_early: busy/err=%b%b before 1000 cycles required 10", busy, err);
        end
        tick();
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_expire: err=%b busy=%b required 1 0", err, busy);
        end
        poll_inv = 1'b0;
        run_op(1, 1'b0, 17'h00010, 8'h00, 1'b0, rd, lat, got);
        n_tests++;
        if (rd !== 8'h10 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_serve: rdata=%h err=%b required 10 1", rd, err);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid_write;
        logic [7:0] rd;
        int         lat;
        bit         got;
        bit         seen;
        bit         bad;
        lock[0] = 1'b1;
        run_op(0, 1'b1, 17'h00100, 8'h11, 1'b1, rd, lat, got);
        wr[0] = 1'b1; addr0 = 17'h00101; wdata0 = 8'h22; req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (nwe === 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_wr_pulse: nwe=1 required 0 within 20 cycles");
        end
        #2;
        nrst = 1'b0;
        #1;
        n_tests++;
        if ({nce, noe, nwe} !== 3'b111 || data_io !== 8'hFF) begin
            n_fail++;
            $display("FAIL rst_async_bus: nce/noe/nwe=%b data=%h required 111 FF", {nce, noe, nwe}, data_io);
        end
        n_tests++;
        if (gnt !== 2'b00 || busy !== 1'b0 || err !== 1'b0 || ack !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: gnt=%b busy=%b err=%b ack=%b required 00 0 0 00", gnt, busy, err, ack);
        end
        req = 2'b00; lock = 2'b00;
        tick(); tick();
        nrst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || nce !== 1'b1) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_no_poll: busy/nce activity after reset, required busy=0 nce=1");
        end
        run_op(1, 1'b0, 17'h00100, 8'h00, 1'b0, rd, lat, got);
        n_tests++;
        if (rd !== 8'h11) begin
            n_fail++;
            $display("FAIL rst_readback: rdata=%h required 11", rd);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_read_p1();
        test_rr();
        test_burst_poll();
        test_timeout();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
